reaction_meter: RTL

- Downstream consumer of the random-delay stimulus timer.
- On `start`, it pulses the timer's enable and waits for the stimulus line to rise. It then measures the elapsed time, in milliseconds, until the player's debounced button press.
- Reports the result, a false start (press before stimulus) or a timeout.
- Sits between the random-delay timer and the display/score logic of the reaction game.

---
 rtl/reaction_pkg.sv | 19 +
 rtl/ms_tick_gen.sv | 38 +++
 rtl/reaction_meter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared state encoding and default constants for reaction_meter
// Purpose: FSM state enum and default TICK_DIV / RESULT_W / TIMEOUT_MS values.
// Ports: none (package).
package reaction_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARM       = 3'd1,
      WAIT_STIM = 3'd2,
      MEASURE   = 3'd3,
      DONE      = 3'd4,
      FAULT     = 3'd5
   } state_t;

   localparam int TICK_DIV_DEF   = 50000;  // 1 ms at 50 MHz
   localparam int RESULT_W_DEF   = 14;
   localparam int TIMEOUT_MS_DEF = 9999;

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - millisecond prescaler producing a one-cycle tick
// Purpose: counts 0..TICK_DIV-1 while enabled and wraps; tick is high in the wrap cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (priority over en)
//   en         : advance the prescaler this cycle
//   tick       : high in the cycle the prescaler wraps
module ms_tick_gen
   import reaction_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + ONE;
      end
   end

endmodule

// File: rtl/reaction_meter.sv
// rtl/reaction_meter.sv - reaction time meter between the random-delay timer and score logic
// Purpose: on a start edge re-arms the stimulus timer, waits for the stimulus edge, then
//   measures milliseconds until a new button press; reports result, false start or timeout.
// Optional feature: define REACTION_BEST_EN to add the best-result register and port.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : round request, rising edge acts
//   stim         : stimulus level from the random-delay timer
//   btn          : debounced, synchronised button level
//   timer_en     : one-cycle pulse re-arming the timer
//   result       : measured reaction time in ms
//   result_valid : result holds a valid measurement
//   false_start  : press seen before the stimulus
//   timeout      : no press within TIMEOUT_MS
//   busy         : round in progress (ARM, WAIT_STIM, MEASURE)
//   best         : smallest valid result since reset (REACTION_BEST_EN only)
module reaction_meter
   import reaction_pkg::*;
#(
   parameter int TICK_DIV   = TICK_DIV_DEF,
   parameter int RESULT_W   = RESULT_W_DEF,
   parameter int TIMEOUT_MS = TIMEOUT_MS_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                stim,
   input  logic                btn,
   output logic                timer_en,
   output logic [RESULT_W-1:0] result,
   output logic                result_valid,
   output logic                false_start,
   output logic                timeout,
   output logic                busy
`ifdef REACTION_BEST_EN
   ,
   output logic [RESULT_W-1:0] best
`endif
);

   localparam logic [RESULT_W-1:0] TO_VAL  = RESULT_W'(TIMEOUT_MS);
   localparam logic [RESULT_W-1:0] TO_LAST = RESULT_W'(TIMEOUT_MS - 1);
   localparam logic [RESULT_W-1:0] ONE     = RESULT_W'(1);

   state_t state, state_nxt;

   logic start_d, stim_d, btn_d;
   logic start_rise, stim_rise, btn_rise;

   logic                tick;
   logic [RESULT_W-1:0] ms_cnt;
   logic [RESULT_W-1:0] ms_now;
   logic                timeout_hit;

   logic                timer_en_nxt;
   logic [RESULT_W-1:0] result_nxt;
   logic                valid_nxt, fs_nxt, to_nxt;

   assign start_rise = start & ~start_d;
   assign stim_rise  = stim  & ~stim_d;
   assign btn_rise   = btn   & ~btn_d;

   // Prescaler only runs while measuring, so it always restarts from 0 on a stim edge.
   ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state != MEASURE),
      .en    (state == MEASURE),
      .tick  (tick)
   );

   // Count as it will be after this cycle's tick, so a press on the wrap cycle
   // reports the wrapped value (including TIMEOUT_MS itself).
   assign ms_now      = tick ? ms_cnt + ONE : ms_cnt;
   assign timeout_hit = tick && (ms_cnt == TO_LAST);

   assign busy = (state == ARM) || (state == WAIT_STIM) || (state == MEASURE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         start_d      <= 1'b0;
         stim_d       <= 1'b0;
         btn_d        <= 1'b0;
         ms_cnt       <= '0;
         timer_en     <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         false_start  <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state        <= state_nxt;
         start_d      <= start;
         stim_d       <= stim;
         btn_d        <= btn;
         timer_en     <= timer_en_nxt;
         result       <= result_nxt;
         result_valid <= valid_nxt;
         false_start  <= fs_nxt;
         timeout      <= to_nxt;
         if (state != MEASURE) begin
            ms_cnt <= '0;
         end else if (tick && (ms_cnt != TO_VAL)) begin
            ms_cnt <= ms_cnt + ONE;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      timer_en_nxt = 1'b0;
      result_nxt   = result;
      valid_nxt    = result_valid;
      fs_nxt       = false_start;
      to_nxt       = timeout;

      case (state)
         IDLE, DONE, FAULT: begin
            if (start_rise) state_nxt = ARM;
         end
         ARM: begin
            state_nxt = WAIT_STIM;
         end
         WAIT_STIM: begin
            if (start_rise) begin
               state_nxt = ARM;
            end else if (btn_rise) begin
               state_nxt = FAULT;
               fs_nxt    = 1'b1;
            end else if (stim_rise) begin
               state_nxt = MEASURE;
            end
         end
         MEASURE: begin
            if (start_rise) begin
               state_nxt = ARM;
            end else if (btn_rise) begin
               state_nxt  = DONE;
               result_nxt = ms_now;
               valid_nxt  = 1'b1;
            end else if (timeout_hit) begin
               state_nxt  = FAULT;
               result_nxt = TO_VAL;
               to_nxt     = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Every path into ARM (fresh round or abort) clears the report and re-arms the timer.
      if (state_nxt == ARM) begin
         timer_en_nxt = 1'b1;
         result_nxt   = '0;
         valid_nxt    = 1'b0;
         fs_nxt       = 1'b0;
         to_nxt       = 1'b0;
      end
   end

`ifdef REACTION_BEST_EN
   logic valid_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best    <= '1;
         valid_d <= 1'b0;
      end else begin
         valid_d <= result_valid;
         if (result_valid && !valid_d && (result < best)) best <= result;
      end
   end
`endif

endmodule
